// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRA/ROR/SRL), one registered stage per shift-amount bit; flags under SHIFTER_FLAGS_EN.
// Latency: $clog2(WIDTH) cycles from acceptance to out_valid, one op per cycle when not stalled.
// Backpressure: the whole pipe freezes while out_valid && !out_ready; in_ready = !stall.
module pipelined_shifter #(
    parameter  int WIDTH   = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic               out_zero,
    output logic               out_carry
`endif
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_SRL = 2'b11;

    logic stall;
    logic advance;

    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int STEP = 1 << k;
        // Each stage consumes the LSB of the remaining shift amount and forwards the rest.
        localparam int SW   = SHAMT_W - k;

        logic             vld_d;
        logic             vld_q;
        logic [WIDTH-1:0] dat_d;
        logic [WIDTH-1:0] dat_n;
        logic [WIDTH-1:0] dat_q;
        logic [SW-1:0]    sh_d;
        logic [1:0]       mode_d;
`ifdef SHIFTER_FLAGS_EN
        logic             carry_d;
        logic             carry_n;
        logic             carry_q;
`endif

        if (k == 0) begin : g_src
            assign vld_d  = in_valid;
            assign dat_d  = in_data;
            assign sh_d   = in_shamt;
            assign mode_d = in_mode;
`ifdef SHIFTER_FLAGS_EN
            assign carry_d = 1'b0;
`endif
        end else begin : g_src
            assign vld_d  = g_stage[k-1].vld_q;
            assign dat_d  = g_stage[k-1].dat_q;
            assign sh_d   = g_stage[k-1].g_fwd.sh_q;
            assign mode_d = g_stage[k-1].g_fwd.mode_q;
`ifdef SHIFTER_FLAGS_EN
            assign carry_d = g_stage[k-1].carry_q;
`endif
        end

        always_comb begin
            dat_n = dat_d;
`ifdef SHIFTER_FLAGS_EN
            carry_n = carry_d;
`endif
            if (sh_d[0]) begin
                case (mode_d)
                    MODE_SLL: dat_n = dat_d << STEP;
                    MODE_SRA: dat_n = $signed(dat_d) >>> STEP;
                    MODE_ROR: dat_n = (dat_d >> STEP) | (dat_d << (WIDTH - STEP));
                    MODE_SRL: dat_n = dat_d >> STEP;
                endcase
`ifdef SHIFTER_FLAGS_EN
                // Last bit to leave the word at this step of the shift.
                carry_n = (mode_d == MODE_SLL) ? dat_d[WIDTH-STEP] : dat_d[STEP-1];
`endif
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
`ifdef SHIFTER_FLAGS_EN
                carry_q <= 1'b0;
`endif
            end else if (advance) begin
                vld_q <= vld_d;
                dat_q <= dat_n;
`ifdef SHIFTER_FLAGS_EN
                carry_q <= carry_n;
`endif
            end
        end

        if (k < SHAMT_W - 1) begin : g_fwd
            logic [SW-2:0] sh_q;
            logic [1:0]    mode_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sh_q   <= '0;
                    mode_q <= '0;
                end else if (advance) begin
                    sh_q   <= sh_d[SW-1:1];
                    mode_q <= mode_d;
                end
            end
        end
    end

    assign out_valid = g_stage[SHAMT_W-1].vld_q;
    assign out_data  = g_stage[SHAMT_W-1].dat_q;

`ifdef SHIFTER_FLAGS_EN
    // Registered rather than decoded from out_data so it reads 0 in reset.
    logic zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (advance) begin
            zero_q <= (g_stage[SHAMT_W-1].dat_n == '0);
        end
    end

    assign out_zero  = zero_q;
    assign out_carry = g_stage[SHAMT_W-1].carry_q;
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter at WIDTH=16 (directed, stream, backpressure, reset)
// plus stream sweeps at WIDTH=8 and WIDTH=32.
module tb_pipelined_shifter;

    typedef struct {
        logic [31:0] dat;
        logic        carry;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] d;
        int          n;
        logic [1:0]  m;
        logic [15:0] q;
        logic        c;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cycle    = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   lat_en;

    exp_t q16[$];
    exp_t q8[$];
    exp_t q32[$];
    exp_t m16, m8, m32;

    // WIDTH=16 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data;
    logic [3:0]  in_shamt;
    logic [1:0]  in_mode;
    // WIDTH=8 instance
    logic        in8_valid, in8_ready, out8_valid;
    logic [7:0]  in8_data, out8_data;
    logic [2:0]  in8_shamt;
    logic [1:0]  in8_mode;
    // WIDTH=32 instance
    logic        in32_valid, in32_ready, out32_valid;
    logic [31:0] in32_data, out32_data;
    logic [4:0]  in32_shamt;
    logic [1:0]  in32_mode;
    logic        sink_rdy = 1'b1;
`ifdef SHIFTER_FLAGS_EN
    logic out_zero, out_carry, out8_zero, out8_carry, out32_zero, out32_carry;
`endif

    vec_t dir_tab[9] = '{
        '{16'h0001, 15, 2'b00, 16'h8000, 1'b0},
        '{16'h8000, 15, 2'b01, 16'hFFFF, 1'b0},
        '{16'h8000, 15, 2'b11, 16'h0001, 1'b0},
        '{16'h1234,  4, 2'b10, 16'h4123, 1'b0},
        '{16'hA5A5,  0, 2'b01, 16'hA5A5, 1'b0},
        '{16'h0001,  1, 2'b11, 16'h0000, 1'b1},
        '{16'hC000,  2, 2'b00, 16'h0000, 1'b1},
        '{16'h8001, 15, 2'b10, 16'h0003, 1'b0},
        '{16'h4000, 15, 2'b01, 16'h0000, 1'b1}
    };

    pipelined_shifter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SHIFTER_FLAGS_EN
        , .out_zero(out_zero), .out_carry(out_carry)
`endif
    );

    pipelined_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data),
        .in_shamt(in8_shamt), .in_mode(in8_mode),
        .out_valid(out8_valid), .out_ready(sink_rdy), .out_data(out8_data)
`ifdef SHIFTER_FLAGS_EN
        , .out_zero(out8_zero), .out_carry(out8_carry)
`endif
    );

    pipelined_shifter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in32_valid), .in_ready(in32_ready), .in_data(in32_data),
        .in_shamt(in32_shamt), .in_mode(in32_mode),
        .out_valid(out32_valid), .out_ready(sink_rdy), .out_data(out32_data)
`ifdef SHIFTER_FLAGS_EN
        , .out_zero(out32_zero), .out_carry(out32_carry)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Direct (non-staged) reference: {carry, data} for a width-w shift of din by n.
    function automatic exp_t model(input int w, input logic [31:0] din, input int n, input logic [1:0] m);
        exp_t        e;
        logic [31:0] mask, d, r;
        logic        c;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        d    = din & mask;
        c    = 1'b0;
        case (m)
            2'b00: begin r = (d << n) & mask; if (n > 0) c = d[w-n]; end
            2'b01: begin
                r = d >> n;
                if (d[w-1]) r = r | (mask & ~(mask >> n));
                if (n > 0) c = d[n-1];
            end
            2'b10: begin r = ((d >> n) | (d << (w - n))) & mask; if (n > 0) c = d[n-1]; end
            default: begin r = d >> n; if (n > 0) c = d[n-1]; end
        endcase
        e.dat   = r;
        e.carry = c;
        e.cyc   = 0;
        return e;
    endfunction

    // Hold the op until accepted; acceptance is judged just before the edge.
    task automatic issue16(input logic [15:0] d, input int n, input logic [1:0] m, input exp_t e);
        int   t;
        logic acc;
        t   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = n[3:0];
        in_mode  = m;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc   = in_ready;
            e.cyc = cycle;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk("w16_accept", 64'(acc), 64'(1));
        else q16.push_back(e);
    endtask

    task automatic drain16(input string tag);
        int t;
        t = 0;
        while (q16.size() != 0 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) begin @(posedge clk); #1; end
        chk(tag, 64'(q16.size()), 64'(0));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q16.size() == 0) chk("w16_unexpected", 64'(out_valid), 64'(0));
            else begin
                m16 = q16[0];
                chk("w16_data", 64'(out_data), 64'(m16.dat));
`ifdef SHIFTER_FLAGS_EN
                chk("w16_carry", 64'(out_carry), 64'(m16.carry));
                chk("w16_zero", 64'(out_zero), 64'(m16.dat == 32'h0));
`endif
                if (lat_en) chk("w16_latency", 64'(cycle - m16.cyc), 64'(4));
                if (out_ready) void'(q16.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out8_valid) begin
            if (q8.size() == 0) chk("w8_unexpected", 64'(out8_valid), 64'(0));
            else begin
                m8 = q8.pop_front();
                chk("w8_data", 64'(out8_data), 64'(m8.dat));
`ifdef SHIFTER_FLAGS_EN
                chk("w8_carry", 64'(out8_carry), 64'(m8.carry));
                chk("w8_zero", 64'(out8_zero), 64'(m8.dat == 32'h0));
`endif
                chk("w8_latency", 64'(cycle - m8.cyc), 64'(3));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out32_valid) begin
            if (q32.size() == 0) chk("w32_unexpected", 64'(out32_valid), 64'(0));
            else begin
                m32 = q32.pop_front();
                chk("w32_data", 64'(out32_data), 64'(m32.dat));
`ifdef SHIFTER_FLAGS_EN
                chk("w32_carry", 64'(out32_carry), 64'(m32.carry));
                chk("w32_zero", 64'(out32_zero), 64'(m32.dat == 32'h0));
`endif
                chk("w32_latency", 64'(cycle - m32.cyc), 64'(5));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          n, t, cnt, n8, n32;
        logic [15:0] d, hold;
        logic [1:0]  m;
        logic [31:0] r;
        exp_t        e;

        rst = 1'b1; lat_en = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
        in8_valid = 1'b0; in8_data = '0; in8_shamt = '0; in8_mode = '0;
        in32_valid = 1'b0; in32_data = '0; in32_shamt = '0; in32_mode = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
`ifdef SHIFTER_FLAGS_EN
        chk("rst_out_zero", 64'(out_zero), 64'(0));
        chk("rst_out_carry", 64'(out_carry), 64'(0));
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rel_in_ready", 64'(in_ready), 64'(1));

        // Directed vectors with hand-derived results
        lat_en = 1'b1;
        foreach (dir_tab[i]) begin
            e.dat   = 32'(dir_tab[i].q);
            e.carry = dir_tab[i].c;
            issue16(dir_tab[i].d, dir_tab[i].n, dir_tab[i].m, e);
        end
        in_valid = 1'b0;
        drain16("dir_drain");

        // Boundary shift in every mode, then a random back-to-back stream
        for (int i = 0; i < 204; i++) begin
            d = 16'($urandom);
            if (i < 4) begin n = 15; m = i[1:0]; end
            else begin n = int'($urandom_range(15, 0)); m = 2'($urandom_range(3, 0)); end
            issue16(d, n, m, model(16, 32'(d), n, m));
        end
        in_valid = 1'b0;
        drain16("stream_drain");

        // Backpressure: hold the sink for 10 cycles after the first result
        lat_en    = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    d = 16'($urandom);
                    n = int'($urandom_range(15, 0));
                    m = 2'($urandom_range(3, 0));
                    issue16(d, n, m, model(16, 32'(d), n, m));
                end
                in_valid = 1'b0;
            end
            begin
                t = 0;
                while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
                chk("bp_valid_seen", 64'(out_valid), 64'(1));
                hold = out_data;
                repeat (10) begin
                    chk("bp_in_ready", 64'(in_ready), 64'(0));
                    chk("bp_hold", 64'(out_data), 64'(hold));
                    @(posedge clk);
                    #1;
                end
                #1;
                out_ready = 1'b1;
            end
        join
        drain16("bp_drain");

        // Asynchronous reset with three ops in flight
        lat_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            issue16(d, 5, 2'b10, model(16, 32'(d), 5, 2'b10));
        end
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
`ifdef SHIFTER_FLAGS_EN
        chk("mid_rst_out_carry", 64'(out_carry), 64'(0));
        chk("mid_rst_out_zero", 64'(out_zero), 64'(0));
`endif
        q16.delete();
        #1 rst = 1'b0;
        chk("mid_rel_in_ready", 64'(in_ready), 64'(1));
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        chk("rst_stale", 64'(cnt), 64'(0));

        // WIDTH=8 and WIDTH=32 streams, boundary shift in every mode first
        for (int i = 0; i < 104; i++) begin
            r = $urandom;
            if (i < 4) begin n8 = 7; n32 = 31; m = i[1:0]; end
            else begin
                n8  = int'($urandom_range(7, 0));
                n32 = int'($urandom_range(31, 0));
                m   = 2'($urandom_range(3, 0));
            end
            in8_valid  = 1'b1; in8_data  = r[7:0]; in8_shamt  = n8[2:0];  in8_mode  = m;
            in32_valid = 1'b1; in32_data = r;      in32_shamt = n32[4:0]; in32_mode = m;
            @(negedge clk);
            if (in8_ready) begin
                e = model(8, 32'(r[7:0]), n8, m);
                e.cyc = cycle;
                q8.push_back(e);
            end
            if (in32_ready) begin
                e = model(32, r, n32, m);
                e.cyc = cycle;
                q32.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in8_valid  = 1'b0;
        in32_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("w8_drain", 64'(q8.size()), 64'(0));
        chk("w32_drain", 64'(q32.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
